chunked_add_sub: RTL

Multi-cycle, parametrised integer add/subtract unit. It processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, and propagates the carry between slices in a register. It returns the sum together with carry, signed-overflow, zero and negative flags. The ALU datapath uses it wherever operand width exceeds what a single-cycle ripple path closes timing at. It also supports add-with-carry and subtract-with-carry for multi-word arithmetic.

---
 rtl/chunked_add_sub.sv | 128 ++++++++++++
 1 files changed

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract unit working CHUNK bits per clock.
// Carry ripples between slices through a register; flags load on the last slice.
module chunked_add_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [CHUNK-1:0] a_k;
   logic [CHUNK-1:0] b_k;
   logic [CHUNK:0]   s_k;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic             carry_r;
   logic             c_msb;
   logic             last;
   logic             accept;
   logic             carry0;

   assign last   = (cnt == CW'(NSLICE - 1));
   assign accept = (state == IDLE) && in_valid && !clear;
   // SUB/SBC share the inverted-B path; only the starting carry differs
   assign carry0 = op[1] ? cin : op[0];

   always_comb begin
      idx    = IW'(32'(cnt) * 32'(CHUNK));
      a_k    = a_r[idx +: CHUNK];
      b_k    = b_r[idx +: CHUNK];
      s_k    = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_r};
      acc_nx = acc;
      acc_nx[idx +: CHUNK] = s_k[CHUNK-1:0];
      c_msb  = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ s_k[CHUNK-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (clear)         state_nx = IDLE;
            else if (in_valid) state_nx = CALC;
         end
         CALC: begin
            if (clear)     state_nx = IDLE;
            else if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (clear || out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         carry_r  <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= op[0] ? ~b : b;
         carry_r <= carry0;
         cnt     <= '0;
      end else if (state == CALC && !clear) begin
         acc     <= acc_nx;
         carry_r <= s_k[CHUNK];
         cnt     <= last ? '0 : cnt + 1'b1;
         if (last) begin
            sum      <= acc_nx;
            cout     <= s_k[CHUNK];
            overflow <= c_msb ^ s_k[CHUNK];
            zero     <= (acc_nx == '0);
            negative <= acc_nx[WIDTH-1];
         end
      end
   end

endmodule
